ecc_job_scheduler: RTL and testbench
====================================

Name: ecc_job_scheduler

Overview:
- Schedules encode/decode/full-channel jobs from two independent requesters onto the single ECC core.
- Acts as the core's APB master: programs CODEWORD_WIDTH, NOISE and DATA_IN, then writes CTRL to launch the operation.
- Waits for operation_done, captures data_out/num_of_errors and returns a tagged response.
- Round-robin arbitration, config-write skipping, completion timeout.

Parameters:
- DATA_WIDTH, 32, width of job data and core data_out
- AMBA_ADDR_WIDTH, 20, APB address width
- AMBA_WORD, 32, APB data width
- TIMEOUT_CYCLES, 16, max cycles in WAIT_DONE before the job is aborted

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  job request from requester 0/1
- req0_ready / req1_ready  out  1  job accepted this cycle (valid&ready)
- reqN_op  in  2  CTRL[1:0]: 00 encode, 01 decode, 10 full channel
- reqN_width  in  2  CODEWORD_WIDTH[1:0]
- reqN_data  in  DATA_WIDTH  DATA_IN value
- reqN_noise  in  AMBA_WORD  NOISE value
- PADDR  out  AMBA_ADDR_WIDTH  APB address to core
- PWDATA  out  AMBA_WORD  APB write data
- PSEL, PENABLE, PWRITE  out  1  APB control (PWRITE always 1)
- operation_done  in  1  core completion pulse
- data_out  in  DATA_WIDTH  core result
- num_of_errors  in  2  core error count
- resp_valid  out  1  response available
- resp_ready  in  1  response consumed
- resp_id  out  1  requester index
- resp_data  out  DATA_WIDTH  captured data_out
- resp_nerr  out  2  captured num_of_errors
- resp_timeout  out  1  job aborted, data invalid

Behaviour:
- Register map (byte addr): CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C.
- Reset values: all outputs 0; state IDLE; rr pointer = requester 0; config cache invalid.
- States: IDLE -> SETUP -> ACCESS -> (next write: SETUP | last write: WAIT_DONE) -> RESP -> IDLE.
- IDLE:
  - If either reqN_valid, grant per round-robin: the pointer names the preferred requester; the other wins only if the preferred one is idle.
  - Assert the winner's ready for exactly one cycle; latch op/width/data/noise/id.
  - Pointer moves to the non-granted requester.
- Write list, in order: CODEWORD_WIDTH, NOISE, DATA_IN, CTRL.
  - CODEWORD_WIDTH is skipped when the cache is valid and holds the same width.
  - NOISE is skipped when op != 10, or when the cache is valid and holds the same noise.
  - DATA_IN and CTRL are never skipped.
  - CTRL is always last, because the CTRL write starts the core.
- APB timing:
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
  - The core has no PREADY, so each write takes exactly 2 cycles. PADDR/PWDATA stay stable across both cycles. PSEL=0 outside writes.
  - Cache updates on completion of the ACCESS cycle of CODEWORD_WIDTH/NOISE.
- WAIT_DONE:
  - Timeout counter clears on entry.
  - operation_done=1: capture data_out and num_of_errors, resp_timeout=0, go to RESP.
  - Counter reaching TIMEOUT_CYCLES-1 without done: resp_data=0, resp_nerr=0, resp_timeout=1, invalidate cache, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP: resp_valid held with stable fields until resp_ready; then IDLE. No new grant until resp_valid drops.
- operation_done outside WAIT_DONE is ignored.
- Latency, encode with warm cache, no stalls:
  - Grant cycle, 2 writes × 2 cycles, then WAIT_DONE.
  - The core raises done 2 cycles after the CTRL ACCESS cycle.
  - resp_valid rises the cycle after done is seen.
- Reset mid-operation: immediate return to reset values.
  - An in-flight APB transfer is dropped (PSEL/PENABLE low).
  - The pending job is lost; requesters re-issue.

Decomposition:
- Shared package ecc_pkg:
  - register address constants (ADDR_CTRL/DATA_IN/CW_WIDTH/NOISE)
  - op codes (OP_ENC=00, OP_DEC=01, OP_FC=10)
  - width codes
  - scheduler state encoding
- Sub-module rr_arbiter2: 2-way round-robin grant with pointer update on accept.

Test Plan:
- Single encode: req0 op=00 width=00 data=0x5.
  - APB writes 0x08←0, 0x04←0x5, 0x00←0 in that order. NOISE not written.
  - Core done with data_out=0x2D → resp id=0 data=0x2D nerr=0 timeout=0.
- Contention: req0 and req1 both valid for 4 jobs each → grants alternate 0,1,0,1…; no starvation; responses in grant order.
- Cache skip: two encodes with width=01 back to back → second job has no write to 0x08. Full channel with noise=0x1 twice → second job has no write to 0x0C.
- Timeout: operation_done held 0 → resp after TIMEOUT_CYCLES in WAIT_DONE, timeout=1 data=0 nerr=0. The next job rewrites 0x08 (cache invalidated).
- Backpressure: resp_ready=0 for 10 cycles with req1 valid → resp fields stable, req1_ready stays 0. Grant happens the cycle after the resp_ready handshake.
- Reset mid-write: assert rst in the ACCESS of 0x04 → PSEL/PENABLE/resp_valid=0 same cycle. After release, IDLE with cache invalid and pointer at requester 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared constants and types for the ECC core job scheduler
package ecc_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_DATA_IN  = 8'h04;
  localparam logic [7:0] ADDR_CW_WIDTH = 8'h08;
  localparam logic [7:0] ADDR_NOISE    = 8'h0C;

  localparam logic [1:0] OP_ENC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_FC  = 2'b10;

  localparam logic [1:0] CW_W8  = 2'b00;
  localparam logic [1:0] CW_W16 = 2'b01;
  localparam logic [1:0] CW_W32 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT_DONE,
    S_RESP
  } sched_state_e;

  // Order of this enum is the order writes are issued; CTRL last starts the core.
  typedef enum logic [1:0] {
    WR_CW,
    WR_NOISE,
    WR_DATA,
    WR_CTRL
  } wr_sel_e;

  function automatic logic [7:0] wr_addr(input wr_sel_e sel);
    case (sel)
      WR_CW:    return ADDR_CW_WIDTH;
      WR_NOISE: return ADDR_NOISE;
      WR_DATA:  return ADDR_DATA_IN;
      default:  return ADDR_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, pointer moves to the loser on accept
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  assign grant[0] = valid[0] & (~ptr | ~valid[1]);
  assign grant[1] = valid[1] & ( ptr | ~valid[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (accept && (|grant)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/ecc_job_scheduler.sv
// rtl/ecc_job_scheduler.sv - arbitrates two job requesters onto the ECC core via APB writes
module ecc_job_scheduler
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [1:0]                 req0_op,
  input  logic [1:0]                 req0_width,
  input  logic [DATA_WIDTH-1:0]      req0_data,
  input  logic [AMBA_WORD-1:0]       req0_noise,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [1:0]                 req1_op,
  input  logic [1:0]                 req1_width,
  input  logic [DATA_WIDTH-1:0]      req1_data,
  input  logic [AMBA_WORD-1:0]       req1_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_id,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic [1:0]                 resp_nerr,
  output logic                       resp_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_e          state;
  wr_sel_e               cur_wr, first_wr, next_wr;
  logic [1:0]            grant;
  logic [1:0]            in_op, in_width, j_op, j_width;
  logic [DATA_WIDTH-1:0] in_data, j_data;
  logic [AMBA_WORD-1:0]  in_noise, j_noise, nz_cache;
  logic [1:0]            cw_cache;
  logic                  cw_valid, nz_valid;
  logic [TW-1:0]         tcnt;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (state == S_IDLE),
    .grant  (grant)
  );

  assign req0_ready = (state == S_IDLE) & grant[0];
  assign req1_ready = (state == S_IDLE) & grant[1];

  function automatic logic [AMBA_WORD-1:0] wr_data(input wr_sel_e sel, input logic [1:0] op,
      input logic [1:0] width, input logic [DATA_WIDTH-1:0] data, input logic [AMBA_WORD-1:0] noise);
    case (sel)
      WR_CW:    return AMBA_WORD'(width);
      WR_NOISE: return noise;
      WR_DATA:  return AMBA_WORD'(data);
      default:  return AMBA_WORD'(op);
    endcase
  endfunction

  // Config writes are skipped when the core already holds the value from an earlier job.
  always_comb begin
    in_op    = grant[1] ? req1_op    : req0_op;
    in_width = grant[1] ? req1_width : req0_width;
    in_data  = grant[1] ? req1_data  : req0_data;
    in_noise = grant[1] ? req1_noise : req0_noise;
    first_wr = WR_DATA;
    if (!(cw_valid && cw_cache == in_width))
      first_wr = WR_CW;
    else if (in_op == OP_FC && !(nz_valid && nz_cache == in_noise))
      first_wr = WR_NOISE;
    next_wr = WR_CTRL;
    case (cur_wr)
      WR_CW:    next_wr = (j_op == OP_FC && !(nz_valid && nz_cache == j_noise)) ? WR_NOISE : WR_DATA;
      WR_NOISE: next_wr = WR_DATA;
      default:  next_wr = WR_CTRL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cur_wr       <= WR_CW;
      j_op         <= '0;
      j_width      <= '0;
      j_data       <= '0;
      j_noise      <= '0;
      cw_valid     <= 1'b0;
      cw_cache     <= '0;
      nz_valid     <= 1'b0;
      nz_cache     <= '0;
      tcnt         <= '0;
      PADDR        <= '0;
      PWDATA       <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_data    <= '0;
      resp_nerr    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      PWRITE <= 1'b1;
      case (state)
        S_IDLE: begin
          if (|grant) begin
            j_op    <= in_op;
            j_width <= in_width;
            j_data  <= in_data;
            j_noise <= in_noise;
            resp_id <= grant[1];
            cur_wr  <= first_wr;
            PADDR   <= AMBA_ADDR_WIDTH'(wr_addr(first_wr));
            PWDATA  <= wr_data(first_wr, in_op, in_width, in_data, in_noise);
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cur_wr == WR_CW) begin
            cw_valid <= 1'b1;
            cw_cache <= j_width;
          end
          if (cur_wr == WR_NOISE) begin
            nz_valid <= 1'b1;
            nz_cache <= j_noise;
          end
          PENABLE <= 1'b0;
          if (cur_wr == WR_CTRL) begin
            PSEL  <= 1'b0;
            tcnt  <= '0;
            state <= S_WAIT_DONE;
          end else begin
            cur_wr <= next_wr;
            PADDR  <= AMBA_ADDR_WIDTH'(wr_addr(next_wr));
            PWDATA <= wr_data(next_wr, j_op, j_width, j_data, j_noise);
            state  <= S_SETUP;
          end
        end
        S_WAIT_DONE: begin
          if (operation_done) begin
            resp_data    <= data_out;
            resp_nerr    <= num_of_errors;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= S_RESP;
          end else if (tcnt == T_LAST) begin
            // The core state is unknown after an abort, so force all config to be rewritten.
            resp_data    <= '0;
            resp_nerr    <= '0;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            cw_valid     <= 1'b0;
            nz_valid     <= 1'b0;
            state        <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_job_scheduler.sv
// tb/tb_ecc_job_scheduler.sv - directed self-checking bench for ecc_job_scheduler
module tb_ecc_job_scheduler;

  typedef struct {
    bit          id;
    logic [31:0] data;
    logic [1:0]  nerr;
    logic        to;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = '0, req1_op = '0, req0_width = '0, req1_width = '0;
  logic [31:0] req0_data = '0, req1_data = '0, req0_noise = '0, req1_noise = '0;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_id;
  logic [31:0] resp_data;
  logic [1:0]  resp_nerr;
  logic        resp_timeout;

  int tests = 0;
  int fails = 0;

  logic        model_done = 1'b0, extra_done = 1'b0, core_en = 1'b1;
  logic [31:0] last_din = '0, core_xor = 32'h28;
  logic [1:0]  core_nerr = 2'd0;
  int          cd = 0, cyc = 0, g_cyc = 0, r_cyc = 0, apb_err = 0;
  logic        prev_setup = 1'b0, prev_rv = 1'b0;
  logic [19:0] s_addr = '0;
  logic [31:0] s_data = '0;
  logic [19:0] wa_q[$];
  logic [31:0] wd_q[$];
  bit          grant_q[$];
  resp_t       resp_q[$];

  assign operation_done = model_done | extra_done;
  assign data_out       = last_din ^ core_xor;
  assign num_of_errors  = core_nerr;

  always #5 clk = ~clk;

  ecc_job_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_width(req0_width),
    .req0_data(req0_data), .req0_noise(req0_noise),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_width(req1_width),
    .req1_data(req1_data), .req1_noise(req1_noise),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .resp_nerr(resp_nerr), .resp_timeout(resp_timeout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Stub core plus bus/grant/response logging, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      cd         <= 0;
      model_done <= 1'b0;
      prev_setup <= 1'b0;
      prev_rv    <= 1'b0;
    end else begin
      model_done <= (cd == 1);
      if (cd > 0) cd <= cd - 1;
      if (PSEL && PENABLE) begin
        wa_q.push_back(PADDR);
        wd_q.push_back(PWDATA);
        if (!prev_setup || PADDR !== s_addr || PWDATA !== s_data || PWRITE !== 1'b1)
          apb_err <= apb_err + 1;
        if (PADDR == 20'h4) last_din <= PWDATA;
        if (PADDR == 20'h0 && core_en) cd <= 2;
      end
      prev_setup <= PSEL && !PENABLE;
      s_addr     <= PADDR;
      s_data     <= PWDATA;
      if (req0_valid && req0_ready) begin grant_q.push_back(1'b0); g_cyc <= cyc; end
      if (req1_valid && req1_ready) begin grant_q.push_back(1'b1); g_cyc <= cyc; end
      if (resp_valid && !prev_rv) r_cyc <= cyc;
      prev_rv <= resp_valid;
      if (resp_valid && resp_ready)
        resp_q.push_back('{id: resp_id, data: resp_data, nerr: resp_nerr, to: resp_timeout});
    end
  end

  function automatic logic [103:0] pack_log();
    logic [103:0] r = '0;
    r[103:96] = 8'(wa_q.size());
    for (int i = 0; i < wa_q.size() && i < 4; i++)
      r[95-24*i -: 24] = {wa_q[i][7:0], wd_q[i][15:0]};
    return r;
  endfunction

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    grant_q.delete();
    resp_q.delete();
  endtask

  task automatic send(input bit id, input logic [1:0] op, input logic [1:0] width,
                      input logic [31:0] data, input logic [31:0] noise);
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (id) begin
      req1_op = op; req1_width = width; req1_data = data; req1_noise = noise; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_width = width; req0_data = data; req0_noise = noise; req0_valid = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL grant_wait id=%0d: got no ready, expected ready", id); end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, output bit ok);
    for (int i = 0; i < 3000; i++) begin
      if (resp_q.size() >= n) break;
      @(negedge clk);
    end
    #1;
    ok = (resp_q.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({PSEL, PENABLE, resp_valid, resp_timeout, resp_id, req0_ready, req1_ready} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {PSEL, PENABLE, resp_valid, resp_timeout, resp_id, req0_ready, req1_ready});
    end
    tests++;
    if ({PADDR, PWDATA, resp_data, resp_nerr} !== '0) begin
      fails++; $display("FAIL reset_data: got %h/%h/%h/%h expected 0", PADDR, PWDATA, resp_data, resp_nerr);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({PSEL, resp_valid} !== 2'b00) begin
      fails++; $display("FAIL idle_after_reset: got %b expected 00", {PSEL, resp_valid});
    end
  endtask

  task automatic test_single_encode();
    bit ok;
    clear_logs();
    core_nerr = 2'd0;
    send(1'b0, 2'b00, 2'b00, 32'h5, 32'h0);
    wait_resp(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_resp_wait: got none expected 1 response"); end
    else begin
      tests++;
      if ({resp_q[0].id, resp_q[0].data, resp_q[0].nerr, resp_q[0].to} !== {1'b0, 32'h2D, 2'd0, 1'b0}) begin
        fails++; $display("FAIL single_resp: got id=%0d data=%h nerr=%0d to=%0d expected id=0 data=2d nerr=0 to=0",
          resp_q[0].id, resp_q[0].data, resp_q[0].nerr, resp_q[0].to);
      end
    end
    tests++;
    if (pack_log() !== {8'd3, 24'h080000, 24'h040005, 24'h000000, 24'h000000}) begin
      fails++; $display("FAIL single_writes: got %h expected 03080000040005000000000000", pack_log());
    end
    tests++;
    if (r_cyc - g_cyc != 9) begin fails++; $display("FAIL cold_latency: got %0d expected 9", r_cyc - g_cyc); end
  endtask

  task automatic test_contention();
    bit ok;
    int cnt[2] = '{0, 0};
    logic [31:0] exp;
    clear_logs();
    core_nerr = 2'd1;
    fork
      begin for (int k = 0; k < 4; k++) send(1'b0, 2'b00, 2'b00, 32'h100 + k, 32'h0); end
      begin for (int k = 0; k < 4; k++) send(1'b1, 2'b00, 2'b00, 32'h200 + k, 32'h0); end
    join
    wait_resp(8, ok);
    tests++;
    if (!ok || grant_q.size() != 8) begin
      fails++; $display("FAIL contention_count: got %0d resps %0d grants expected 8 8", resp_q.size(), grant_q.size());
    end
    for (int i = 0; i < grant_q.size(); i++) begin
      tests++;
      if (grant_q[i] !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL contention_grant[%0d]: got %0d expected %0d", i, grant_q[i], (i % 2 == 0));
      end
    end
    for (int i = 0; i < resp_q.size() && i < grant_q.size(); i++) begin
      exp = ((resp_q[i].id ? 32'h200 : 32'h100) + 32'(cnt[resp_q[i].id])) ^ 32'h28;
      cnt[resp_q[i].id]++;
      tests++;
      if ({resp_q[i].id, resp_q[i].data, resp_q[i].nerr, resp_q[i].to} !== {grant_q[i], exp, 2'd1, 1'b0}) begin
        fails++; $display("FAIL contention_resp[%0d]: got id=%0d data=%h nerr=%0d expected id=%0d data=%h nerr=1",
          i, resp_q[i].id, resp_q[i].data, resp_q[i].nerr, grant_q[i], exp);
      end
    end
  endtask

  task automatic test_cache_skip();
    bit ok;
    logic [103:0] exp_log[4];
    logic [31:0]  din[4];
    exp_log[0] = {8'd3, 24'h080001, 24'h040033, 24'h000000, 24'h000000};
    exp_log[1] = {8'd2, 24'h040034, 24'h000000, 24'h000000, 24'h000000};
    exp_log[2] = {8'd3, 24'h0C0001, 24'h040035, 24'h000002, 24'h000000};
    exp_log[3] = {8'd2, 24'h040036, 24'h000002, 24'h000000, 24'h000000};
    din = '{32'h33, 32'h34, 32'h35, 32'h36};
    core_nerr = 2'd3;
    for (int j = 0; j < 4; j++) begin
      clear_logs();
      send(1'b0, (j < 2) ? 2'b00 : 2'b10, 2'b01, din[j], 32'h1);
      wait_resp(1, ok);
      tests++;
      if (pack_log() !== exp_log[j]) begin
        fails++; $display("FAIL cache_writes[%0d]: got %h expected %h", j, pack_log(), exp_log[j]);
      end
      tests++;
      if (!ok || resp_q[0].data !== (din[j] ^ 32'h28) || resp_q[0].nerr !== 2'd3) begin
        fails++; $display("FAIL cache_resp[%0d]: got %0d resps expected data %h nerr 3", j, resp_q.size(), din[j] ^ 32'h28);
      end
    end
    tests++;
    if (r_cyc - g_cyc != 7) begin fails++; $display("FAIL warm_latency: got %0d expected 7", r_cyc - g_cyc); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    core_en = 1'b0;
    send(1'b1, 2'b00, 2'b01, 32'h44, 32'h0);
    wait_resp(1, ok);
    tests++;
    if (!ok || {resp_q[0].id, resp_q[0].data, resp_q[0].nerr, resp_q[0].to} !== {1'b1, 32'h0, 2'd0, 1'b1}) begin
      fails++; $display("FAIL timeout_resp: got %0d resps expected id=1 data=0 nerr=0 to=1", resp_q.size());
    end
    tests++;
    if (r_cyc - g_cyc != 21) begin fails++; $display("FAIL timeout_latency: got %0d expected 21", r_cyc - g_cyc); end
    core_en = 1'b1;
    clear_logs();
    send(1'b0, 2'b00, 2'b01, 32'h45, 32'h0);
    wait_resp(1, ok);
    tests++;
    if (pack_log() !== {8'd3, 24'h080001, 24'h040045, 24'h000000, 24'h000000}) begin
      fails++; $display("FAIL after_timeout_writes: got %h expected 03080001040045000000000000", pack_log());
    end
  endtask

  task automatic test_backpressure();
    bit ok = 1'b0;
    logic [35:0] snap;
    clear_logs();
    resp_ready = 1'b0;
    send(1'b0, 2'b00, 2'b01, 32'h55, 32'h0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    snap = {resp_id, resp_data, resp_nerr, resp_timeout};
    tests++;
    if (!ok || snap !== {1'b0, 32'h55 ^ 32'h28, 2'd3, 1'b0}) begin
      fails++; $display("FAIL bp_resp: got %h expected %h", snap, {1'b0, 32'h55 ^ 32'h28, 2'd3, 1'b0});
    end
    @(posedge clk); #1;
    req1_op = 2'b00; req1_width = 2'b01; req1_data = 32'h56; req1_noise = '0; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({resp_valid, resp_id, resp_data, resp_nerr, resp_timeout, req1_ready} !== {1'b1, snap, 1'b0}) begin
        fails++; $display("FAIL bp_hold[%0d]: got valid=%0d fields=%h ready=%0d expected 1/%h/0",
          i, resp_valid, {resp_id, resp_data, resp_nerr, resp_timeout}, req1_ready, snap);
      end
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (req1_ready !== 1'b0) begin fails++; $display("FAIL bp_handshake_cycle: got ready=%0d expected 0", req1_ready); end
    @(negedge clk);
    tests++;
    if (req1_ready !== 1'b1) begin fails++; $display("FAIL bp_next_grant: got ready=%0d expected 1", req1_ready); end
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_resp(2, ok);
    tests++;
    if (!ok || resp_q[1].id !== 1'b1 || resp_q[1].data !== (32'h56 ^ 32'h28)) begin
      fails++; $display("FAIL bp_second_resp: got %0d resps expected id=1 data=%h", resp_q.size(), 32'h56 ^ 32'h28);
    end
  endtask

  task automatic test_done_ignored();
    bit ok;
    clear_logs();
    @(posedge clk); #1 extra_done = 1'b1;
    @(posedge clk); #1 extra_done = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({resp_valid, PSEL} !== 2'b00) begin fails++; $display("FAIL idle_done: got %b expected 00", {resp_valid, PSEL}); end
    send(1'b1, 2'b00, 2'b01, 32'h77, 32'h0);
    extra_done = 1'b1;
    @(posedge clk); #1 extra_done = 1'b0;
    wait_resp(1, ok);
    tests++;
    if (!ok || resp_q[0].data !== (32'h77 ^ 32'h28) || (r_cyc - g_cyc) != 7) begin
      fails++; $display("FAIL setup_done: got %0d resps latency %0d expected data %h latency 7",
        resp_q.size(), r_cyc - g_cyc, 32'h77 ^ 32'h28);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok = 1'b0;
    send(1'b0, 2'b00, 2'b10, 32'h66, 32'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE && PADDR == 20'h4) begin ok = 1'b1; break; end
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (!ok || {PSEL, PENABLE, resp_valid} !== 3'b000) begin
      fails++; $display("FAIL reset_mid_write: got %b found=%0d expected 000", {PSEL, PENABLE, resp_valid}, ok);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    clear_logs();
    @(posedge clk); #1;
    req0_op = 2'b00; req0_width = 2'b10; req0_data = 32'h67; req0_valid = 1'b1;
    req1_op = 2'b00; req1_width = 2'b10; req1_data = 32'h68; req1_valid = 1'b1;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL reset_pointer: got %b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(1, ok);
    tests++;
    if (pack_log() !== {8'd3, 24'h080002, 24'h040067, 24'h000000, 24'h000000}) begin
      fails++; $display("FAIL reset_cache: got %h expected 03080002040067000000000000", pack_log());
    end
    tests++;
    if (!ok || resp_q[0].data !== (32'h67 ^ 32'h28)) begin
      fails++; $display("FAIL reset_resp: got %0d resps expected data %h", resp_q.size(), 32'h67 ^ 32'h28);
    end
  endtask

  task automatic test_apb_protocol();
    tests++;
    if (apb_err != 0) begin fails++; $display("FAIL apb_stability: got %0d bad access cycles expected 0", apb_err); end
  endtask

  initial begin
    test_reset();
    test_single_encode();
    test_contention();
    test_cache_skip();
    test_timeout();
    test_backpressure();
    test_done_ignored();
    test_reset_mid_write();
    test_apb_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
